// File: rtl/cla_nibble_seq_adder_if.sv
// Operand/result handshake bundle for the nibble-serial CLA adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface cla_nibble_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle adder/subtractor: one shared 4-bit carry-lookahead slice processes
// one operand nibble per cycle, LSB first, with the carry held in a register.
module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of generate/propagate terms; none waits on its neighbour.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sum
            assign sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign c_out = c[4];
endmodule

// WIDTH must be a multiple of 4 and at least 8.
module cla_nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cla_nibble_seq_adder_if.slave     bus
);
    localparam int NIBS  = WIDTH / 4;
    localparam int CNT_W = $clog2(NIBS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               c_out_reg;
    logic               ovf_reg;
    logic               zero_reg;

    logic               accept;
    logic               step;
    logic               last;
    logic               in_ready_c;
    logic               out_valid_c;

    logic [3:0]         a_nibs [NIBS];
    logic [3:0]         b_nibs [NIBS];
    logic [3:0]         slice_a;
    logic [3:0]         slice_b;
    logic [3:0]         slice_sum;
    logic               slice_c_out;
    logic [WIDTH-1:0]   sum_next;
    logic               ovf_next;

    generate
        for (genvar gi = 0; gi < NIBS; gi++) begin : g_nib
            assign a_nibs[gi] = a_reg[4*gi +: 4];
            assign b_nibs[gi] = b_reg[4*gi +: 4];
            // Only the nibble being processed this cycle is replaced.
            assign sum_next[4*gi +: 4] = (cnt_reg == CNT_W'(gi)) ? slice_sum : sum_reg[4*gi +: 4];
        end
    endgenerate

    assign slice_a = a_nibs[cnt_reg];
    assign slice_b = b_nibs[cnt_reg];

    cla_4b u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_reg),
        .sum   (slice_sum),
        .c_out (slice_c_out)
    );

    // b_reg already holds B' (inverted for subtract), so one rule covers both operations.
    assign ovf_next = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (slice_sum[3] != a_reg[WIDTH-1]);

    always_comb begin
        state_next  = state_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        last        = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= bus.a;
                b_reg     <= bus.b ^ {WIDTH{bus.sub}};
                carry_reg <= bus.sub;
                cnt_reg   <= '0;
            end else if (step) begin
                sum_reg   <= sum_next;
                carry_reg <= slice_c_out;
                cnt_reg   <= cnt_reg + CNT_W'(1);
                if (last) begin
                    c_out_reg <= slice_c_out;
                    ovf_reg   <= ovf_next;
                    zero_reg  <= (sum_next == '0);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_reg;
    assign bus.c_out     = c_out_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// Directed bench for the nibble-serial CLA adder: arithmetic corners, latency,
// backpressure and asynchronous reset in the middle of an operation.
module tb_cla_nibble_seq_adder;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    cla_nibble_seq_adder_if #(.WIDTH(16)) bus ();

    cla_nibble_seq_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction and returns what the DUT presented plus cycles from accept to out_valid.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output logic [15:0] s, output logic c, output logic o,
                         output logic z, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s = bus.sum;
        c = bus.c_out;
        o = bus.ovf;
        z = bus.zero;
        $display("op a=%h b=%h sub=%0d -> sum=%h c_out=%0d ovf=%0d zero=%0d lat=%0d",
                 a, b, sub, s, c, o, z, lat);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.c_out, bus.ovf, bus.zero} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {bus.out_valid, bus.c_out, bus.ovf, bus.zero});
        end
        checks++;
        if (bus.sum !== 16'h0000) begin
            failures++;
            $display("FAIL reset_sum got=%h want=0000", bus.sum);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        $display("reset released in_ready=%b", bus.in_ready);
    endtask

    task automatic test_add();
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        do_op(16'h1234, 16'h4321, 1'b0, s, c, o, z, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL add_latency got=%0d want=4", lat);
        end
        checks++;
        if ({s, c, o, z} !== {16'h5555, 3'b000}) begin
            failures++;
            $display("FAIL add_result got=%h/%b%b%b want=5555/000", s, c, o, z);
        end
    endtask

    task automatic test_carry_chain();
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        do_op(16'h0FFF, 16'h0001, 1'b0, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z} !== {16'h1000, 3'b000}) begin
            failures++;
            $display("FAIL ripple_result got=%h/%b%b%b want=1000/000", s, c, o, z);
        end
        do_op(16'hFFFF, 16'h0001, 1'b0, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z} !== {16'h0000, 3'b101}) begin
            failures++;
            $display("FAIL wrap_result got=%h/%b%b%b want=0000/101", s, c, o, z);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        do_op(16'h7FFF, 16'h0001, 1'b0, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z} !== {16'h8000, 3'b010}) begin
            failures++;
            $display("FAIL ovf_add got=%h/%b%b%b want=8000/010", s, c, o, z);
        end
        do_op(16'h8000, 16'h0001, 1'b1, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z} !== {16'h7FFF, 3'b110}) begin
            failures++;
            $display("FAIL ovf_sub got=%h/%b%b%b want=7fff/110", s, c, o, z);
        end
    endtask

    task automatic test_subtract();
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        do_op(16'h0005, 16'h0007, 1'b1, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z} !== {16'hFFFE, 3'b000}) begin
            failures++;
            $display("FAIL sub_borrow got=%h/%b%b%b want=fffe/000", s, c, o, z);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL sub_latency got=%0d want=4", lat);
        end
        do_op(16'h0007, 16'h0007, 1'b1, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z} !== {16'h0000, 3'b101}) begin
            failures++;
            $display("FAIL sub_equal got=%h/%b%b%b want=0000/101", s, c, o, z);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        @(negedge clk);
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL bp_latency got=%0d want=4", lat);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) begin
                bus.a        = 16'h0100;
                bus.b        = 16'h0200;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.sum} !== {2'b10, 16'h3333}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%b%b/%h want=10/3333",
                         i, bus.out_valid, bus.in_ready, bus.sum);
            end
            $display("bp cycle=%0d out_valid=%b in_ready=%b sum=%h", i, bus.out_valid, bus.in_ready, bus.sum);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release got=%b%b want=01", bus.out_valid, bus.in_ready);
        end
        do_op(16'h0100, 16'h0200, 1'b0, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z, lat} !== {16'h0300, 3'b000, 32'd4}) begin
            failures++;
            $display("FAIL bp_second got=%h/%b%b%b lat=%0d want=0300/000 lat=4", s, c, o, z, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s;
        logic        c, o, z;
        int          lat;
        @(negedge clk);
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.sum, bus.c_out, bus.zero} !== {1'b0, 16'h0000, 2'b00}) begin
            failures++;
            $display("FAIL midrst_clear got=%b/%h/%b%b want=0/0000/00",
                     bus.out_valid, bus.sum, bus.c_out, bus.zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL midrst_idle got=%b%b want=01", bus.out_valid, bus.in_ready);
        end
        $display("mid-run reset out_valid=%b in_ready=%b sum=%h", bus.out_valid, bus.in_ready, bus.sum);
        do_op(16'h0001, 16'h0002, 1'b0, s, c, o, z, lat);
        checks++;
        if ({s, c, o, z, lat} !== {16'h0003, 3'b000, 32'd4}) begin
            failures++;
            $display("FAIL midrst_fresh got=%h/%b%b%b lat=%0d want=0003/000 lat=4", s, c, o, z, lat);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_carry_chain();
        test_overflow();
        test_subtract();
        test_backpressure();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
